// File: rtl/synth_voice_allocator.sv
// Voice-slot allocator for the polyphonic generator bank: decodes note commands
// into one slot write each, keeping the voice table, steal pointer and waveform select.
module synth_voice_allocator #(
  parameter int NUM_VOICES = 10,
  parameter int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_valid,
  input  logic [15:0]           i_cmd_data,
  output logic                  o_cmd_ready,
  output logic                  o_voice_we,
  output logic [IDX_W-1:0]      o_voice_idx,
  output logic [6:0]            o_voice_note,
  output logic [7:0]            o_voice_velocity,
  output logic                  o_voice_active,
  output logic [NUM_VOICES-1:0] o_active_mask,
  output logic [1:0]            o_wave_sel,
  output logic                  o_steal
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_CLEAR  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  logic [1:0]            r_state;
  logic                  r_cmd_on;
  logic [6:0]            r_cmd_note;
  logic [7:0]            r_cmd_vel;
  logic [IDX_W-1:0]      r_scan;
  logic                  r_match_found;
  logic [IDX_W-1:0]      r_match_idx;
  logic                  r_free_found;
  logic [IDX_W-1:0]      r_free_idx;
  logic [IDX_W-1:0]      r_steal_ptr;
  logic [NUM_VOICES-1:0] r_tbl_active;
  logic [6:0]            r_tbl_note [NUM_VOICES];
  logic                  r_voice_we;
  logic [IDX_W-1:0]      r_voice_idx;
  logic [6:0]            r_voice_note;
  logic [7:0]            r_voice_vel;
  logic                  r_voice_active;
  logic [1:0]            r_wave_sel;
  logic                  r_steal;

  logic                  w_accept;
  logic                  w_is_wave;
  logic                  w_is_stop;
  logic                  w_slot_match;
  logic                  w_any_match;
  logic [IDX_W-1:0]      w_match_idx;
  logic                  w_any_free;
  logic [IDX_W-1:0]      w_free_idx;

  assign o_cmd_ready = (r_state == S_IDLE);
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_is_wave   = i_cmd_data[15] && (i_cmd_data[14:8] == 7'd0);
  assign w_is_stop   = !i_cmd_data[15] && (i_cmd_data[14:8] == 7'h7F);

  // Fold the slot under the scan pointer into the running "first match / first free"
  // results so the last SEARCH cycle can decide without an extra cycle.
  assign w_slot_match = r_tbl_active[r_scan] && (r_tbl_note[r_scan] == r_cmd_note);
  assign w_any_match  = r_match_found || w_slot_match;
  assign w_match_idx  = r_match_found ? r_match_idx : r_scan;
  assign w_any_free   = r_free_found || !r_tbl_active[r_scan];
  assign w_free_idx   = r_free_found ? r_free_idx : r_scan;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make the table update order-dependent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cmd_on       <= 1'b0;
      r_cmd_note     <= 7'd0;
      r_cmd_vel      <= 8'd0;
      r_scan         <= '0;
      r_match_found  <= 1'b0;
      r_match_idx    <= '0;
      r_free_found   <= 1'b0;
      r_free_idx     <= '0;
      r_steal_ptr    <= '0;
      r_tbl_active   <= '0;
      // NOTE: the table is a small flop array, not RAM, so it can be reset in place.
      for (int i = 0; i < NUM_VOICES; i++) r_tbl_note[i] <= 7'd0;
      r_voice_we     <= 1'b0;
      r_voice_idx    <= '0;
      r_voice_note   <= 7'd0;
      r_voice_vel    <= 8'd0;
      r_voice_active <= 1'b0;
      r_wave_sel     <= 2'd0;
      r_steal        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_wave) begin
              r_wave_sel <= r_wave_sel + 2'd1;
            end else if (w_is_stop) begin
              r_state        <= S_CLEAR;
              r_voice_we     <= 1'b1;
              r_voice_idx    <= '0;
              r_voice_note   <= 7'd0;
              r_voice_vel    <= 8'd0;
              r_voice_active <= 1'b0;
            end else begin
              r_state       <= S_SEARCH;
              r_cmd_on      <= i_cmd_data[15];
              r_cmd_note    <= i_cmd_data[14:8];
              r_cmd_vel     <= i_cmd_data[7:0];
              r_scan        <= '0;
              r_match_found <= 1'b0;
              r_free_found  <= 1'b0;
            end
          end
        end
        S_SEARCH: begin
          r_match_found <= w_any_match;
          r_match_idx   <= w_match_idx;
          r_free_found  <= w_any_free;
          r_free_idx    <= w_free_idx;
          if (r_scan == LAST_IDX) begin
            r_state <= S_COMMIT;
            if (r_cmd_on) begin
              r_voice_we     <= 1'b1;
              r_voice_note   <= r_cmd_note;
              r_voice_vel    <= r_cmd_vel;
              r_voice_active <= 1'b1;
              if (w_any_match) begin
                r_voice_idx <= w_match_idx;
              end else if (w_any_free) begin
                r_voice_idx <= w_free_idx;
              end else begin
                r_voice_idx <= r_steal_ptr;
                r_steal     <= 1'b1;
                r_steal_ptr <= (r_steal_ptr == LAST_IDX) ? '0 : r_steal_ptr + 1'b1;
              end
            end else if (w_any_match) begin
              r_voice_we     <= 1'b1;
              r_voice_idx    <= w_match_idx;
              r_voice_note   <= r_cmd_note;
              r_voice_vel    <= r_cmd_vel;
              r_voice_active <= 1'b0;
            end
          end else begin
            r_scan <= r_scan + 1'b1;
          end
        end
        S_COMMIT: begin
          if (r_voice_we) begin
            r_tbl_active[r_voice_idx] <= r_voice_active;
            r_tbl_note[r_voice_idx]   <= r_voice_note;
          end
          r_voice_we <= 1'b0;
          r_steal    <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_CLEAR: begin
          r_tbl_active[r_voice_idx] <= 1'b0;
          r_tbl_note[r_voice_idx]   <= 7'd0;
          if (r_voice_idx == LAST_IDX) begin
            r_voice_we  <= 1'b0;
            r_steal_ptr <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_voice_idx <= r_voice_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_voice_we       = r_voice_we;
  assign o_voice_idx      = r_voice_idx;
  assign o_voice_note     = r_voice_note;
  assign o_voice_velocity = r_voice_vel;
  assign o_voice_active   = r_voice_active;
  assign o_active_mask    = r_tbl_active;
  assign o_wave_sel       = r_wave_sel;
  assign o_steal          = r_steal;

endmodule

// File: tb/tb_synth_voice_allocator.sv
// Scoreboard bench for synth_voice_allocator: directed commands push expected slot
// writes; a negedge monitor pops and compares every write strobe it sees.
module tb_synth_voice_allocator;

  localparam int NV = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic [15:0]   i_cmd_data = 16'd0;
  logic          o_cmd_ready;
  logic          o_voice_we;
  logic [3:0]    o_voice_idx;
  logic [6:0]    o_voice_note;
  logic [7:0]    o_voice_velocity;
  logic          o_voice_active;
  logic [NV-1:0] o_active_mask;
  logic [1:0]    o_wave_sel;
  logic          o_steal;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  synth_voice_allocator #(.NUM_VOICES(NV)) dut (
    .clk(clk), .reset(reset), .i_cmd_valid(i_cmd_valid), .i_cmd_data(i_cmd_data),
    .o_cmd_ready(o_cmd_ready), .o_voice_we(o_voice_we), .o_voice_idx(o_voice_idx),
    .o_voice_note(o_voice_note), .o_voice_velocity(o_voice_velocity),
    .o_voice_active(o_voice_active), .o_active_mask(o_active_mask),
    .o_wave_sel(o_wave_sel), .o_steal(o_steal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int idx, input int note, input int vel,
                                     input int act, input int st);
    return {11'd0, 1'(st), 1'(act), 8'(vel), 7'(note), 4'(idx)};
  endfunction

  function automatic logic [15:0] on_cmd(input int note, input int vel);
    return {1'b1, 7'(note), 8'(vel)};
  endfunction

  function automatic logic [31:0] cur_pk();
    return pk(int'(o_voice_idx), int'(o_voice_note), int'(o_voice_velocity),
              int'(o_voice_active), int'(o_steal));
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (o_voice_we) begin
      if (exp_q.size() == 0) check("unexpected_write", cur_pk(), 32'hFFFF_FFFF);
      else                   check("voice_write", cur_pk(), exp_q.pop_front());
    end else if (o_steal) begin
      check("steal_without_write", {31'd0, o_steal}, 32'd0);
    end
  end

  // Issue one command from a negedge; returns cycles until ready is high again.
  task automatic send(input logic [15:0] cmd, output int lat);
    int n;
    n = 0;
    while (!o_cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    i_cmd_valid = 1'b1;
    i_cmd_data  = cmd;
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o_cmd_ready && lat < 100);
  endtask

  task automatic cmd(input logic [15:0] c, input int exp_lat, input string name);
    int lat;
    send(c, lat);
    check(name, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_voice_regs", cur_pk(), pk(0, 0, 0, 0, 0));
    check("reset_we", {31'd0, o_voice_we}, 32'd0);
    check("reset_ready", {31'd0, o_cmd_ready}, 32'd1);
    check("reset_mask", 32'(o_active_mask), 32'd0);
    check("reset_wave", 32'(o_wave_sel), 32'd0);
    reset = 1'b0;

    // Waveform cycling: one cycle each, no slot writes.
    for (int w = 1; w <= 4; w++) begin
      cmd(16'h8000, 1, "wave_lat");
      check("wave_sel", 32'(o_wave_sel), 32'(w % 4));
    end

    // First note-on lands in slot 0.
    check("ready_at_accept", {31'd0, o_cmd_ready}, 32'd1);
    exp_q.push_back(pk(0, 69, 0, 1, 0));
    cmd(16'hC500, 12, "note_on_lat");
    check("mask_one", 32'(o_active_mask), 32'h001);

    for (int i = 1; i < NV; i++) begin
      exp_q.push_back(pk(i, 69 + i, 16 + i, 1, 0));
      cmd(on_cmd(69 + i, 16 + i), 12, "fill_lat");
    end
    check("mask_full", 32'(o_active_mask), 32'h3FF);

    // Overflow steals slot 0, then slot 1.
    exp_q.push_back(pk(0, 79, 8'h22, 1, 1));
    cmd(on_cmd(79, 8'h22), 12, "steal0_lat");
    exp_q.push_back(pk(1, 80, 8'h23, 1, 1));
    cmd(on_cmd(80, 8'h23), 12, "steal1_lat");
    check("mask_after_steal", 32'(o_active_mask), 32'h3FF);

    cmd(16'h8000, 1, "wave_lat2");
    check("wave_before_stop", 32'(o_wave_sel), 32'd1);

    // STOP_ALL clears every slot, leaves the waveform alone.
    for (int i = 0; i < NV; i++) exp_q.push_back(pk(i, 0, 0, 0, 0));
    cmd(16'h7F00, 11, "stop_lat");
    check("mask_after_stop", 32'(o_active_mask), 32'd0);
    check("wave_after_stop", 32'(o_wave_sel), 32'd1);

    // Steal pointer restarts at 0 after STOP_ALL.
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(pk(i, 30 + i, 8'h50, 1, 0));
      cmd(on_cmd(30 + i, 8'h50), 12, "refill_lat");
    end
    exp_q.push_back(pk(0, 40, 8'h51, 1, 1));
    cmd(on_cmd(40, 8'h51), 12, "steal_restart_lat");
    for (int i = 0; i < NV; i++) exp_q.push_back(pk(i, 0, 0, 0, 0));
    cmd(16'h7F00, 11, "stop_lat2");
    check("mask_after_stop2", 32'(o_active_mask), 32'd0);

    // Retrigger, note-off, and note-off that matches nothing.
    exp_q.push_back(pk(0, 69, 8'h11, 1, 0));
    cmd(on_cmd(69, 8'h11), 12, "on69_lat");
    exp_q.push_back(pk(0, 69, 8'h40, 1, 0));
    cmd(on_cmd(69, 8'h40), 12, "retrig_lat");
    check("mask_retrig", 32'(o_active_mask), 32'h001);
    exp_q.push_back(pk(0, 69, 0, 0, 0));
    cmd(16'h4500, 12, "off69_lat");
    check("mask_off69", 32'(o_active_mask), 32'd0);
    cmd(16'h4900, 12, "off73_nomatch_lat");
    check("mask_off73", 32'(o_active_mask), 32'd0);

    // Reset in the middle of a note-on search discards it.
    exp_q.push_back(pk(0, 20, 8'h33, 1, 0));
    cmd(on_cmd(20, 8'h33), 12, "on20_lat");
    check("mask_on20", 32'(o_active_mask), 32'h001);
    i_cmd_valid = 1'b1;
    i_cmd_data  = on_cmd(50, 5);
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_in_search", {31'd0, o_cmd_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_voice_regs", cur_pk(), pk(0, 0, 0, 0, 0));
    check("midrst_mask", 32'(o_active_mask), 32'd0);
    check("midrst_wave", 32'(o_wave_sel), 32'd0);
    check("midrst_ready", {31'd0, o_cmd_ready}, 32'd1);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("idle_after_midrst", {31'd0, o_cmd_ready}, 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
